// File: rtl/sec_mem_req_arbiter_pkg.sv
// Shared definitions for the secure memory request arbiter: port ids,
// arbiter state encoding and the memory message field layout.
package sec_mem_req_arbiter_pkg;

    // Port ids; the id also travels in opaque bit SEC_ARB_OPQ_TAG_BIT
    localparam logic SEC_ARB_PORT_IMEM = 1'b0;
    localparam logic SEC_ARB_PORT_DMEM = 1'b1;

    typedef enum logic {
        SEC_ARB_IDLE   = 1'b0,
        SEC_ARB_LOCKED = 1'b1
    } sec_arb_state_e;

    // Bit of the opaque field that carries the issuing port id
    localparam int SEC_ARB_OPQ_TAG_BIT = 0;

    // Memory message fields, MSB first:
    //   request  = {type, opaque, addr, len, data}
    //   response = {type, opaque, len, data}
    localparam int MEM_TYPE_NBITS = 3;
    localparam int MEM_ADDR_NBITS = 32;
    localparam int MEM_LEN_NBITS  = 2;
    localparam int MEM_DATA_NBITS = 32;

    // Message widths excluding the opaque field
    localparam int MEM_REQ_FIXED_NBITS  = MEM_TYPE_NBITS + MEM_ADDR_NBITS
                                        + MEM_LEN_NBITS + MEM_DATA_NBITS;
    localparam int MEM_RESP_FIXED_NBITS = MEM_TYPE_NBITS + MEM_LEN_NBITS
                                        + MEM_DATA_NBITS;

    // LSB position of the opaque field inside each message
    localparam int MEM_REQ_OPQ_LSB  = MEM_ADDR_NBITS + MEM_LEN_NBITS + MEM_DATA_NBITS;
    localparam int MEM_RESP_OPQ_LSB = MEM_LEN_NBITS + MEM_DATA_NBITS;

endpackage

// File: rtl/sec_mem_req_arbiter_opq_fifo.sv
// Small in-order FIFO holding the original opaque values of in-flight
// requests for one port. The caller guarantees no push when full and
// no pop when empty (the outstanding counter gates both).
module sec_mem_req_arbiter_opq_fifo #(
    parameter int p_depth = 2,
    parameter int p_nbits = 8
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    input  logic [p_nbits-1:0] enq_msg,
    input  logic               deq_rdy,
    output logic [p_nbits-1:0] deq_msg
);

    localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;

    logic [p_nbits-1:0] mem [p_depth];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(p_depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer bookkeeping; reset empties the queue
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_val) wr_ptr <= ptr_inc(wr_ptr);
            if (deq_rdy) rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (enq_val) mem[wr_ptr] <= enq_msg;
    end

    assign deq_msg = mem[rd_ptr];

endmodule

// File: rtl/sec_mem_req_arbiter.sv
// Two-port (imem/dmem) arbiter in front of a single memory port.
// Round-robin grant, grant held while memory stalls, per-port limit on
// in-flight requests. Responses are steered back by opaque bit 0 and get
// their original opaque value restored from a per-port FIFO.
module sec_mem_req_arbiter
    import sec_mem_req_arbiter_pkg::*;
#(
    parameter int p_max_outstanding = 2,
    parameter int p_opaque_nbits    = 8
)(
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [MEM_REQ_FIXED_NBITS+p_opaque_nbits-1:0]    req0_msg,
    input  logic                                             req0_val,
    output logic                                             req0_rdy,
    input  logic                                             req0_domain,
    output logic [MEM_RESP_FIXED_NBITS+p_opaque_nbits-1:0]   resp0_msg,
    output logic                                             resp0_val,
    input  logic                                             resp0_rdy,
    input  logic [MEM_REQ_FIXED_NBITS+p_opaque_nbits-1:0]    req1_msg,
    input  logic                                             req1_val,
    output logic                                             req1_rdy,
    input  logic                                             req1_domain,
    output logic [MEM_RESP_FIXED_NBITS+p_opaque_nbits-1:0]   resp1_msg,
    output logic                                             resp1_val,
    input  logic                                             resp1_rdy,
    output logic [MEM_REQ_FIXED_NBITS+p_opaque_nbits-1:0]    memreq_msg,
    output logic                                             memreq_val,
    input  logic                                             memreq_rdy,
    output logic                                             memreq_domain,
    input  logic [MEM_RESP_FIXED_NBITS+p_opaque_nbits-1:0]   memresp_msg,
    input  logic                                             memresp_val,
    output logic                                             memresp_rdy
);

    localparam int CNT_W    = $clog2(p_max_outstanding + 1);
    localparam int TAG_REQ  = MEM_REQ_OPQ_LSB + SEC_ARB_OPQ_TAG_BIT;
    localparam int TAG_RESP = MEM_RESP_OPQ_LSB + SEC_ARB_OPQ_TAG_BIT;

    sec_arb_state_e      state_q, state_d;
    logic                lock_port_q;
    logic                rr_prio_q;
    logic [CNT_W-1:0]    cnt0_q, cnt1_q;
    logic                elig0, elig1;
    logic                gnt, gnt_val;
    logic                inc0, inc1;
    logic                resp_port, resp_live;
    logic                resp0_fire, resp1_fire;
    logic [p_opaque_nbits-1:0] head0, head1;

    // Eligibility and grant selection; LOCKED pins the grant to the stalled port
    always_comb begin
        elig0   = req0_val && (cnt0_q < CNT_W'(p_max_outstanding));
        elig1   = req1_val && (cnt1_q < CNT_W'(p_max_outstanding));
        gnt     = SEC_ARB_PORT_IMEM;
        if (state_q == SEC_ARB_LOCKED)  gnt = lock_port_q;
        else if (elig0 && elig1)        gnt = rr_prio_q;
        else if (elig1)                 gnt = SEC_ARB_PORT_DMEM;
        gnt_val = gnt ? elig1 : elig0;
    end

    // State register; the locked port is captured on every IDLE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEC_ARB_IDLE;
            lock_port_q <= SEC_ARB_PORT_IMEM;
        end else begin
            state_q <= state_d;
            if (state_q == SEC_ARB_IDLE) lock_port_q <= gnt;
        end
    end

    // Next state: lock on a presented-but-stalled request, release on fire
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEC_ARB_IDLE:   if (gnt_val && !memreq_rdy) state_d = SEC_ARB_LOCKED;
            SEC_ARB_LOCKED: if (!gnt_val || memreq_rdy) state_d = SEC_ARB_IDLE;
        endcase
    end

    // Request-side outputs; opaque tag bit replaced by the granted port id
    always_comb begin
        memreq_val    = !reset && gnt_val;
        req0_rdy      = !reset && gnt_val && memreq_rdy && (gnt == SEC_ARB_PORT_IMEM);
        req1_rdy      = !reset && gnt_val && memreq_rdy && (gnt == SEC_ARB_PORT_DMEM);
        memreq_msg    = gnt ? req1_msg : req0_msg;
        memreq_msg[TAG_REQ] = gnt;
        memreq_domain = gnt ? req1_domain : req0_domain;
        inc0          = req0_val && req0_rdy;
        inc1          = req1_val && req1_rdy;
    end

    // Response steering; a response for a port with nothing in flight is swallowed
    always_comb begin
        resp_port   = memresp_msg[TAG_RESP];
        resp_live   = resp_port ? (cnt1_q != '0) : (cnt0_q != '0);
        resp0_val   = !reset && memresp_val && resp_live && (resp_port == SEC_ARB_PORT_IMEM);
        resp1_val   = !reset && memresp_val && resp_live && (resp_port == SEC_ARB_PORT_DMEM);
        memresp_rdy = !reset && (resp_live ? (resp_port ? resp1_rdy : resp0_rdy) : 1'b1);
        resp0_msg   = memresp_msg;
        resp0_msg[MEM_RESP_OPQ_LSB +: p_opaque_nbits] = head0;
        resp1_msg   = memresp_msg;
        resp1_msg[MEM_RESP_OPQ_LSB +: p_opaque_nbits] = head1;
        resp0_fire  = resp0_val && resp0_rdy;
        resp1_fire  = resp1_val && resp1_rdy;
    end

    // Round-robin pointer moves to the other port after each request fire
    always_ff @(posedge clk) begin
        if (reset)              rr_prio_q <= SEC_ARB_PORT_IMEM;
        else if (inc0 || inc1)  rr_prio_q <= ~gnt;
    end

    // Outstanding counters; simultaneous issue and return cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_q + CNT_W'(inc0) - CNT_W'(resp0_fire);
            cnt1_q <= cnt1_q + CNT_W'(inc1) - CNT_W'(resp1_fire);
        end
    end

    sec_mem_req_arbiter_opq_fifo #(
        .p_depth (p_max_outstanding),
        .p_nbits (p_opaque_nbits)
    ) u_opq_fifo0 (
        .clk     (clk),
        .reset   (reset),
        .enq_val (inc0),
        .enq_msg (req0_msg[MEM_REQ_OPQ_LSB +: p_opaque_nbits]),
        .deq_rdy (resp0_fire),
        .deq_msg (head0)
    );

    sec_mem_req_arbiter_opq_fifo #(
        .p_depth (p_max_outstanding),
        .p_nbits (p_opaque_nbits)
    ) u_opq_fifo1 (
        .clk     (clk),
        .reset   (reset),
        .enq_val (inc1),
        .enq_msg (req1_msg[MEM_REQ_OPQ_LSB +: p_opaque_nbits]),
        .deq_rdy (resp1_fire),
        .deq_msg (head1)
    );

    // A response must belong to a port with a request in flight
    a_resp_has_owner: assert property (@(posedge clk) disable iff (reset)
        memresp_val |-> resp_live);

endmodule

// File: tb/tb_sec_mem_req_arbiter.sv
// Directed bench for sec_mem_req_arbiter (p_max_outstanding=2, opaque 8 bits).
module tb_sec_mem_req_arbiter;

    logic        clk, reset;
    logic [76:0] req0_msg, req1_msg, memreq_msg;
    logic [44:0] resp0_msg, resp1_msg, memresp_msg;
    logic        req0_val, req0_rdy, req0_domain, resp0_val, resp0_rdy;
    logic        req1_val, req1_rdy, req1_domain, resp1_val, resp1_rdy;
    logic        memreq_val, memreq_rdy, memreq_domain;
    logic        memresp_val, memresp_rdy;

    int total = 0;
    int bad   = 0;

    sec_mem_req_arbiter #(
        .p_max_outstanding (2),
        .p_opaque_nbits    (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req0_msg      (req0_msg),
        .req0_val      (req0_val),
        .req0_rdy      (req0_rdy),
        .req0_domain   (req0_domain),
        .resp0_msg     (resp0_msg),
        .resp0_val     (resp0_val),
        .resp0_rdy     (resp0_rdy),
        .req1_msg      (req1_msg),
        .req1_val      (req1_val),
        .req1_rdy      (req1_rdy),
        .req1_domain   (req1_domain),
        .resp1_msg     (resp1_msg),
        .resp1_val     (resp1_val),
        .resp1_rdy     (resp1_rdy),
        .memreq_msg    (memreq_msg),
        .memreq_val    (memreq_val),
        .memreq_rdy    (memreq_rdy),
        .memreq_domain (memreq_domain),
        .memresp_msg   (memresp_msg),
        .memresp_val   (memresp_val),
        .memresp_rdy   (memresp_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] opq,
                                           input logic [31:0] addr, input logic [31:0] data);
        return {t, opq, addr, 2'b00, data};
    endfunction

    function automatic logic [44:0] mk_resp(input logic [2:0] t, input logic [7:0] opq,
                                            input logic [31:0] data);
        return {t, opq, 2'b00, data};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic clear_inputs;
        req0_val = 0; req1_val = 0; memreq_rdy = 0; memresp_val = 0;
        resp0_rdy = 0; resp1_rdy = 0; req0_domain = 0; req1_domain = 0;
    endtask

    task automatic test_reset;
        reset = 1; req0_val = 1; req1_val = 1; memreq_rdy = 1;
        resp0_rdy = 1; resp1_rdy = 1; memresp_val = 1;
        memresp_msg = mk_resp(3'd0, 8'h01, 32'h0);
        settle;
        total++; if (memreq_val !== 1'b0) begin bad++; $display("FAIL reset_memreq_val got=%b want=0", memreq_val); end
        total++; if (req0_rdy !== 1'b0) begin bad++; $display("FAIL reset_req0_rdy got=%b want=0", req0_rdy); end
        total++; if (req1_rdy !== 1'b0) begin bad++; $display("FAIL reset_req1_rdy got=%b want=0", req1_rdy); end
        total++; if (resp0_val !== 1'b0 || resp1_val !== 1'b0) begin bad++; $display("FAIL reset_resp_val got=%b%b want=00", resp0_val, resp1_val); end
        total++; if (memresp_rdy !== 1'b0) begin bad++; $display("FAIL reset_memresp_rdy got=%b want=0", memresp_rdy); end
        tick;
        clear_inputs;
        reset = 0;
        settle;
        total++; if (memreq_val !== 1'b0) begin bad++; $display("FAIL idle_memreq_val got=%b want=0", memreq_val); end
        tick;
    endtask

    task automatic test_round_robin;
        logic [76:0] e;
        logic        pp;
        logic [7:0]  eo;
        logic [31:0] ed;
        req0_msg = mk_req(3'd0, 8'h11, 32'h1000, 32'h0);
        req1_msg = mk_req(3'd1, 8'h20, 32'h2000, 32'hCAFE0001);
        memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
        for (int k = 0; k < 5; k++) begin
            req0_val = (k < 4);
            req1_val = (k < 4);
            pp = ((k - 1) % 2 == 1);
            ed = 32'hA0000000 + 32'(k);
            if (k > 0) begin
                memresp_val = 1;
                memresp_msg = mk_resp(3'd0, pp ? 8'h21 : 8'h10, ed);
            end else begin
                memresp_val = 0;
            end
            settle;
            if (k < 4) begin
                e = (k % 2 == 0) ? mk_req(3'd0, 8'h10, 32'h1000, 32'h0)
                                 : mk_req(3'd1, 8'h21, 32'h2000, 32'hCAFE0001);
                total++; if (memreq_val !== 1'b1) begin bad++; $display("FAIL rr_val k=%0d got=%b want=1", k, memreq_val); end
                total++; if (memreq_msg !== e) begin bad++; $display("FAIL rr_msg k=%0d got=%h want=%h", k, memreq_msg, e); end
            end else begin
                total++; if (memreq_val !== 1'b0) begin bad++; $display("FAIL rr_idle k=%0d got=%b want=0", k, memreq_val); end
            end
            if (k > 0) begin
                eo = pp ? 8'h20 : 8'h11;
                total++; if ((pp ? resp1_val : resp0_val) !== 1'b1 || (pp ? resp0_val : resp1_val) !== 1'b0)
                    begin bad++; $display("FAIL rr_resp_val k=%0d got=%b%b want port %0d", k, resp1_val, resp0_val, pp); end
                total++; if ((pp ? resp1_msg[41:34] : resp0_msg[41:34]) !== eo)
                    begin bad++; $display("FAIL rr_resp_opq k=%0d got=%h want=%h", k, pp ? resp1_msg[41:34] : resp0_msg[41:34], eo); end
                total++; if ((pp ? resp1_msg[31:0] : resp0_msg[31:0]) !== ed)
                    begin bad++; $display("FAIL rr_resp_data k=%0d got=%h want=%h", k, pp ? resp1_msg[31:0] : resp0_msg[31:0], ed); end
            end
            tick;
        end
        clear_inputs;
    endtask

    task automatic test_sticky_grant;
        logic [76:0] e1, e0;
        e1 = mk_req(3'd1, 8'h21, 32'h2000, 32'h000000B1);
        e0 = mk_req(3'd0, 8'h30, 32'h1004, 32'h0);
        req1_msg = e1;
        req0_msg = e0;
        req1_val = 1;
        for (int k = 0; k < 4; k++) begin
            req0_val = (k >= 1);
            memreq_rdy = (k == 3);
            settle;
            total++; if (memreq_val !== 1'b1) begin bad++; $display("FAIL sticky_val k=%0d got=%b want=1", k, memreq_val); end
            total++; if (memreq_msg !== e1) begin bad++; $display("FAIL sticky_msg k=%0d got=%h want=%h", k, memreq_msg, e1); end
            total++; if (req1_rdy !== (k == 3)) begin bad++; $display("FAIL sticky_req1_rdy k=%0d got=%b want=%b", k, req1_rdy, (k == 3)); end
            total++; if (req0_rdy !== 1'b0) begin bad++; $display("FAIL sticky_req0_rdy k=%0d got=%b want=0", k, req0_rdy); end
            tick;
        end
        req1_val = 0;
        req0_val = 1;
        memreq_rdy = 1;
        settle;
        total++; if (memreq_msg !== e0) begin bad++; $display("FAIL sticky_next_msg got=%h want=%h", memreq_msg, e0); end
        total++; if (req0_rdy !== 1'b1) begin bad++; $display("FAIL sticky_next_rdy got=%b want=1", req0_rdy); end
        tick;
        clear_inputs;
        resp0_rdy = 1; resp1_rdy = 1;
        memresp_val = 1;
        memresp_msg = mk_resp(3'd0, 8'h21, 32'h1);
        settle;
        total++; if (resp1_val !== 1'b1 || resp1_msg[41:34] !== 8'h21) begin bad++; $display("FAIL sticky_drain1 got val=%b opq=%h want 1 21", resp1_val, resp1_msg[41:34]); end
        tick;
        memresp_msg = mk_resp(3'd0, 8'h30, 32'h2);
        settle;
        total++; if (resp0_val !== 1'b1 || resp0_msg[41:34] !== 8'h30) begin bad++; $display("FAIL sticky_drain0 got val=%b opq=%h want 1 30", resp0_val, resp0_msg[41:34]); end
        tick;
        clear_inputs;
    endtask

    task automatic test_outstanding_limit;
        req0_val = 1; req1_val = 0; memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
        req1_msg = mk_req(3'd1, 8'h60, 32'h2040, 32'h0);
        req0_msg = mk_req(3'd0, 8'h41, 32'h1040, 32'h0);
        settle;
        total++; if (req0_rdy !== 1'b1) begin bad++; $display("FAIL lim_first got=%b want=1", req0_rdy); end
        tick;
        req0_msg = mk_req(3'd0, 8'h43, 32'h1044, 32'h0);
        settle;
        total++; if (req0_rdy !== 1'b1) begin bad++; $display("FAIL lim_second got=%b want=1", req0_rdy); end
        tick;
        req0_msg = mk_req(3'd0, 8'h45, 32'h1048, 32'h0);
        settle;
        total++; if (req0_rdy !== 1'b0 || memreq_val !== 1'b0) begin bad++; $display("FAIL lim_third_stall got rdy=%b val=%b want 0 0", req0_rdy, memreq_val); end
        tick;
        req1_val = 1;
        settle;
        total++; if (req1_rdy !== 1'b1 || req0_rdy !== 1'b0) begin bad++; $display("FAIL lim_port1_passes got rdy1=%b rdy0=%b want 1 0", req1_rdy, req0_rdy); end
        tick;
        req1_val = 0;
        memresp_val = 1;
        memresp_msg = mk_resp(3'd0, 8'h40, 32'h10);
        settle;
        total++; if (resp0_val !== 1'b1 || resp0_msg[41:34] !== 8'h41) begin bad++; $display("FAIL lim_resp_a got val=%b opq=%h want 1 41", resp0_val, resp0_msg[41:34]); end
        total++; if (req0_rdy !== 1'b0) begin bad++; $display("FAIL lim_still_blocked got=%b want=0", req0_rdy); end
        tick;
        memresp_msg = mk_resp(3'd0, 8'h42, 32'h11);
        settle;
        total++; if (req0_rdy !== 1'b1) begin bad++; $display("FAIL lim_unblock got=%b want=1", req0_rdy); end
        total++; if (resp0_val !== 1'b1 || resp0_msg[41:34] !== 8'h43) begin bad++; $display("FAIL lim_resp_b got val=%b opq=%h want 1 43", resp0_val, resp0_msg[41:34]); end
        tick;
        memresp_val = 0;
        req0_msg = mk_req(3'd0, 8'h47, 32'h104C, 32'h0);
        settle;
        total++; if (req0_rdy !== 1'b1) begin bad++; $display("FAIL lim_same_cycle_count got=%b want=1", req0_rdy); end
        tick;
        settle;
        total++; if (req0_rdy !== 1'b0) begin bad++; $display("FAIL lim_full_again got=%b want=0", req0_rdy); end
        req0_val = 0;
        memresp_val = 1;
        memresp_msg = mk_resp(3'd0, 8'h61, 32'h12);
        settle;
        total++; if (resp1_val !== 1'b1 || resp1_msg[41:34] !== 8'h60) begin bad++; $display("FAIL lim_drain1 got val=%b opq=%h want 1 60", resp1_val, resp1_msg[41:34]); end
        tick;
        memresp_msg = mk_resp(3'd0, 8'h44, 32'h13);
        settle;
        total++; if (resp0_msg[41:34] !== 8'h45) begin bad++; $display("FAIL lim_drain0a got=%h want=45", resp0_msg[41:34]); end
        tick;
        memresp_msg = mk_resp(3'd0, 8'h46, 32'h14);
        settle;
        total++; if (resp0_msg[41:34] !== 8'h47) begin bad++; $display("FAIL lim_drain0b got=%h want=47", resp0_msg[41:34]); end
        tick;
        clear_inputs;
    endtask

    task automatic test_opaque_routing;
        req0_msg = mk_req(3'd0, 8'h5A, 32'h1300, 32'h0);
        req1_msg = mk_req(3'd1, 8'h33, 32'h2300, 32'h0);
        req0_val = 1; req1_val = 1; memreq_rdy = 1;
        settle;
        total++; if (memreq_msg[73:66] !== 8'h33 || memreq_msg[66] !== 1'b1) begin bad++; $display("FAIL opq_req1 got=%h want=33", memreq_msg[73:66]); end
        tick;
        settle;
        total++; if (memreq_msg[73:66] !== 8'h5A || memreq_msg[66] !== 1'b0) begin bad++; $display("FAIL opq_req0 got=%h want=5a", memreq_msg[73:66]); end
        tick;
        req0_val = 0; req1_val = 0;
        memresp_val = 1; resp1_rdy = 0; resp0_rdy = 1;
        memresp_msg = mk_resp(3'd0, 8'h33, 32'hDEADBEEF);
        settle;
        total++; if (resp1_val !== 1'b1 || memresp_rdy !== 1'b0 || resp0_val !== 1'b0)
            begin bad++; $display("FAIL opq_backpressure got v1=%b rdy=%b v0=%b want 1 0 0", resp1_val, memresp_rdy, resp0_val); end
        tick;
        resp1_rdy = 1;
        settle;
        total++; if (memresp_rdy !== 1'b1 || resp1_msg[41:34] !== 8'h33 || resp1_msg[31:0] !== 32'hDEADBEEF)
            begin bad++; $display("FAIL opq_resp1 got rdy=%b opq=%h data=%h want 1 33 deadbeef", memresp_rdy, resp1_msg[41:34], resp1_msg[31:0]); end
        tick;
        memresp_msg = mk_resp(3'd0, 8'h5A, 32'h12345678);
        settle;
        total++; if (resp0_val !== 1'b1 || resp1_val !== 1'b0 || resp0_msg[41:34] !== 8'h5A || resp0_msg[31:0] !== 32'h12345678)
            begin bad++; $display("FAIL opq_resp0 got v0=%b v1=%b opq=%h data=%h want 1 0 5a 12345678", resp0_val, resp1_val, resp0_msg[41:34], resp0_msg[31:0]); end
        tick;
        clear_inputs;
    endtask

    task automatic test_domain;
        logic eg, pg, ed;
        req0_msg = mk_req(3'd0, 8'h50, 32'h1200, 32'h0);
        req1_msg = mk_req(3'd1, 8'h51, 32'h2200, 32'h0);
        memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
        for (int k = 0; k < 5; k++) begin
            req0_val = (k < 4);
            req1_val = (k < 4);
            req0_domain = (k >= 2);
            req1_domain = (k < 2);
            eg = (k % 2 == 0);
            pg = ((k - 1) % 2 == 0);
            ed = eg ? (k < 2) : (k >= 2);
            if (k > 0) begin
                memresp_val = 1;
                memresp_msg = mk_resp(3'd0, pg ? 8'h51 : 8'h50, 32'h0);
            end else begin
                memresp_val = 0;
            end
            settle;
            if (k < 4) begin
                total++; if (memreq_val !== 1'b1 || memreq_msg[66] !== eg) begin bad++; $display("FAIL dom_grant k=%0d got=%b want=%b", k, memreq_msg[66], eg); end
                total++; if (memreq_domain !== ed) begin bad++; $display("FAIL dom_value k=%0d got=%b want=%b", k, memreq_domain, ed); end
            end
            if (k > 0) begin
                total++; if ((pg ? resp1_val : resp0_val) !== 1'b1) begin bad++; $display("FAIL dom_resp k=%0d got=%b%b want port %0d", k, resp1_val, resp0_val, pg); end
            end
            tick;
        end
        clear_inputs;
    endtask

    task automatic test_reset_locked;
        req0_msg = mk_req(3'd0, 8'h70, 32'h1100, 32'h0);
        req1_msg = mk_req(3'd1, 8'h71, 32'h2100, 32'h0);
        req0_val = 1; req1_val = 1; memreq_rdy = 1;
        tick;
        tick;
        memreq_rdy = 0;
        settle;
        total++; if (memreq_val !== 1'b1 || memreq_msg[66] !== 1'b1) begin bad++; $display("FAIL rl_pre_grant got val=%b g=%b want 1 1", memreq_val, memreq_msg[66]); end
        tick;
        reset = 1; memreq_rdy = 1; memresp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
        memresp_msg = mk_resp(3'd0, 8'h70, 32'h0);
        settle;
        total++; if ({memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy} !== 6'b0)
            begin bad++; $display("FAIL rl_outputs got=%b want=000000", {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy}); end
        tick;
        reset = 0; memresp_val = 0;
        settle;
        total++; if (memreq_val !== 1'b1 || memreq_msg[66] !== 1'b0 || req0_rdy !== 1'b1)
            begin bad++; $display("FAIL rl_first_grant got val=%b g=%b rdy0=%b want 1 0 1", memreq_val, memreq_msg[66], req0_rdy); end
        tick;
        clear_inputs;
    endtask

    initial begin
        reset = 1;
        clear_inputs;
        req0_msg = '0; req1_msg = '0; memresp_msg = '0;
        tick;
        tick;
        test_reset;
        test_round_robin;
        test_sticky_grant;
        test_outstanding_limit;
        test_opaque_routing;
        test_domain;
        test_reset_locked;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
